rtc_calendar_counter: RTL and testbench

- Parametrised real-time clock/calendar with an internal 1 Hz prescaler.
- Counts sec/min/hour/day/month/year with full Gregorian leap-year rules.
- Accepts time/date loads through a validated valid/ready handshake.
- Drives registered binary fields plus 14 seven-segment digit outputs for the board display.

---
 rtl/rtc_calendar_counter.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_rtc_calendar_counter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_calendar_counter.sv
// -----------------------------------------------------------------------------
// rtc_calendar_counter
//   Real-time clock / calendar with an internal 1 Hz prescaler, full Gregorian
//   leap-year handling, a validated valid/ready time/date load path and a
//   registered 14-digit seven-segment display image.
//
// Optional feature macro: RTC_ALARM_EN (adds an hour:minute alarm).
//
// Parameters
//   CLK_DIV        clk cycles per second tick (>= 2)
//   RESET_YEAR     year loaded on reset (0..9999)
//   SEG_ACTIVE_LOW 1 = segment bits inverted (common anode), 0 = active high
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   1 = prescaler counts, 0 = time frozen
//   load_valid/ready      load handshake; load_* carry the binary fields
//   load_err              one-cycle pulse when a captured load is rejected
//   *_bin                 current time/date, binary
//   sec_pulse             one-cycle pulse whenever the second advances
//   seg[97:0]             14 digits x gfedcba, LSB-first: sec0, sec1, min0,
//                         min1, hour0, hour1, day0, day1, month0, month1,
//                         year0..year3
//   alarm_set/hour/min    (RTC_ALARM_EN) latch alarm time and arm
//   alarm_clr, alarm      (RTC_ALARM_EN) sticky alarm flag and its clear
// -----------------------------------------------------------------------------
module rtc_calendar_counter #(
  parameter int CLK_DIV        = 50000000,
  parameter int RESET_YEAR     = 2024,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [5:0]  load_sec,
  input  logic [5:0]  load_min,
  input  logic [4:0]  load_hour,
  input  logic [4:0]  load_day,
  input  logic [3:0]  load_month,
  input  logic [13:0] load_year,
  output logic        load_err,
  output logic [5:0]  sec_bin,
  output logic [5:0]  min_bin,
  output logic [4:0]  hour_bin,
  output logic [4:0]  day_bin,
  output logic [3:0]  month_bin,
  output logic [13:0] year_bin,
  output logic        sec_pulse,
  output logic [97:0] seg
`ifdef RTC_ALARM_EN
  ,
  input  logic        alarm_set,
  input  logic [4:0]  alarm_hour,
  input  logic [5:0]  alarm_min,
  input  logic        alarm_clr,
  output logic        alarm
`endif
);

  localparam int              PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [13:0]     RST_YEAR  = 14'(RESET_YEAR);

  typedef enum logic {ST_RUN = 1'b0, ST_CHECK = 1'b1} state_t;

  function automatic logic is_leap(input logic [13:0] y);
    return ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // Fields are always in range, so every BCD digit is 0..9.
  function automatic logic [97:0] seg_encode(input logic [5:0] s, input logic [5:0] mi,
                                             input logic [4:0] h, input logic [4:0] d,
                                             input logic [3:0] mo, input logic [13:0] y);
    return {seg7(4'(y / 14'd1000)),
            seg7(4'((y / 14'd100) % 14'd10)),
            seg7(4'((y / 14'd10) % 14'd10)),
            seg7(4'(y % 14'd10)),
            seg7(4'(mo / 4'd10)), seg7(4'(mo % 4'd10)),
            seg7(4'(d / 5'd10)),  seg7(4'(d % 5'd10)),
            seg7(4'(h / 5'd10)),  seg7(4'(h % 5'd10)),
            seg7(4'(mi / 6'd10)), seg7(4'(mi % 6'd10)),
            seg7(4'(s / 6'd10)),  seg7(4'(s % 6'd10))};
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d, day_q, day_d;
  logic [3:0]    month_q, month_d;
  logic [13:0]   year_q, year_d;
  logic          load_ready_q, load_ready_d;
  logic          load_err_q, load_err_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic [97:0]   seg_q;

  logic [5:0]    ld_sec_q, ld_min_q;
  logic [4:0]    ld_hour_q, ld_day_q;
  logic [3:0]    ld_month_q;
  logic [13:0]   ld_year_q;

  logic [5:0]    adv_sec, adv_min;
  logic [4:0]    adv_hour, adv_day;
  logic [3:0]    adv_month;
  logic [13:0]   adv_year;
  logic          tick;
  logic          accept;
  logic          ld_ok;

  // Current time plus one second, with the full carry chain resolved in one step.
  always_comb begin
    adv_sec   = sec_q;
    adv_min   = min_q;
    adv_hour  = hour_q;
    adv_day   = day_q;
    adv_month = month_q;
    adv_year  = year_q;
    if (sec_q != 6'd59) begin
      adv_sec = sec_q + 6'd1;
    end else begin
      adv_sec = 6'd0;
      if (min_q != 6'd59) begin
        adv_min = min_q + 6'd1;
      end else begin
        adv_min = 6'd0;
        if (hour_q != 5'd23) begin
          adv_hour = hour_q + 5'd1;
        end else begin
          adv_hour = 5'd0;
          if (day_q != days_in_month(month_q, year_q)) begin
            adv_day = day_q + 5'd1;
          end else begin
            adv_day = 5'd1;
            if (month_q != 4'd12) begin
              adv_month = month_q + 4'd1;
            end else begin
              adv_month = 4'd1;
              adv_year  = (year_q == 14'd9999) ? 14'd0 : year_q + 14'd1;
            end
          end
        end
      end
    end
  end

  assign accept = (state_q == ST_RUN) && load_valid && load_ready_q;

  assign ld_ok = (ld_sec_q <= 6'd59) && (ld_min_q <= 6'd59) && (ld_hour_q <= 5'd23) &&
                 (ld_month_q >= 4'd1) && (ld_month_q <= 4'd12) &&
                 (ld_day_q >= 5'd1) && (ld_day_q <= days_in_month(ld_month_q, ld_year_q)) &&
                 (ld_year_q <= 14'd9999);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    load_ready_d = load_ready_q;
    load_err_d   = 1'b0;
    sec_pulse_d  = 1'b0;
    tick         = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (run) begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick    = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        if (tick) begin
          sec_pulse_d = 1'b1;
          sec_d       = adv_sec;
          min_d       = adv_min;
          hour_d      = adv_hour;
          day_d       = adv_day;
          month_d     = adv_month;
          year_d      = adv_year;
        end
        if (accept) begin
          state_d      = ST_CHECK;
          load_ready_d = 1'b0;
        end
      end
      ST_CHECK: begin
        // A valid load overrides any tick applied on the accepting edge.
        if (ld_ok) begin
          sec_d   = ld_sec_q;
          min_d   = ld_min_q;
          hour_d  = ld_hour_q;
          day_d   = ld_day_q;
          month_d = ld_month_q;
          year_d  = ld_year_q;
          presc_d = '0;
        end else begin
          load_err_d = 1'b1;
        end
        state_d      = ST_RUN;
        load_ready_d = 1'b1;
      end
    endcase
  end

  // Control and time state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      presc_q      <= '0;
      sec_q        <= 6'd0;
      min_q        <= 6'd0;
      hour_q       <= 5'd0;
      day_q        <= 5'd1;
      month_q      <= 4'd1;
      year_q       <= RST_YEAR;
      load_ready_q <= 1'b1;
      load_err_q   <= 1'b0;
      sec_pulse_q  <= 1'b0;
      seg_q        <= seg_encode(6'd0, 6'd0, 5'd0, 5'd1, 4'd1, RST_YEAR);
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      load_ready_q <= load_ready_d;
      load_err_q   <= load_err_d;
      sec_pulse_q  <= sec_pulse_d;
      // Display image trails the binary fields by one cycle.
      seg_q        <= seg_encode(sec_q, min_q, hour_q, day_q, month_q, year_q);
    end
  end

  // Load capture; only meaningful while in CHECK, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      ld_sec_q   <= load_sec;
      ld_min_q   <= load_min;
      ld_hour_q  <= load_hour;
      ld_day_q   <= load_day;
      ld_month_q <= load_month;
      ld_year_q  <= load_year;
    end
  end

  assign load_ready = load_ready_q;
  assign load_err   = load_err_q;
  assign sec_pulse  = sec_pulse_q;
  assign sec_bin    = sec_q;
  assign min_bin    = min_q;
  assign hour_bin   = hour_q;
  assign day_bin    = day_q;
  assign month_bin  = month_q;
  assign year_bin   = year_q;
  assign seg        = seg_q;

`ifdef RTC_ALARM_EN
  logic       armed_q;
  logic [4:0] al_hour_q;
  logic [5:0] al_min_q;
  logic       alarm_q;
  logic       alarm_hit;

  // Match only on a tick that lands exactly on hh:mm:00.
  assign alarm_hit = armed_q && tick && (adv_hour == al_hour_q) &&
                     (adv_min == al_min_q) && (adv_sec == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b0;
      al_hour_q <= 5'd0;
      al_min_q  <= 6'd0;
      alarm_q   <= 1'b0;
    end else begin
      if (alarm_set) begin
        armed_q   <= 1'b1;
        al_hour_q <= alarm_hour;
        al_min_q  <= alarm_min;
      end
      if (alarm_clr) begin
        alarm_q <= 1'b0;
      end else if (alarm_hit) begin
        alarm_q <= 1'b1;
      end
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// -----------------------------------------------------------------------------
// tb_rtc_calendar_counter
//   Self-checking bench for rtc_calendar_counter (CLK_DIV = 4). A behavioural
//   calendar model (integer fields, month-length table, leap rule) predicts
//   every output after each clock edge; directed loads cover wrap and leap
//   boundaries, then randomized run/load traffic is compared cycle by cycle.
//   With RTC_ALARM_EN defined the alarm output is modelled and checked too.
// -----------------------------------------------------------------------------
module tb_rtc_calendar_counter;

  localparam int CLK_DIV    = 4;
  localparam int RESET_YEAR = 2024;
  localparam bit SEG_AL     = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [5:0]  load_sec = '0;
  logic [5:0]  load_min = '0;
  logic [4:0]  load_hour = '0;
  logic [4:0]  load_day = '0;
  logic [3:0]  load_month = '0;
  logic [13:0] load_year = '0;
  logic        load_err;
  logic [5:0]  sec_bin, min_bin;
  logic [4:0]  hour_bin, day_bin;
  logic [3:0]  month_bin;
  logic [13:0] year_bin;
  logic        sec_pulse;
  logic [97:0] seg;
  logic        alarm_set = 1'b0;
  logic [4:0]  alarm_hour = '0;
  logic [5:0]  alarm_min = '0;
  logic        alarm_clr = 1'b0;
`ifdef RTC_ALARM_EN
  logic        alarm;
`endif

  always #5 clk = ~clk;

  rtc_calendar_counter #(
    .CLK_DIV(CLK_DIV), .RESET_YEAR(RESET_YEAR), .SEG_ACTIVE_LOW(SEG_AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .load_err(load_err),
    .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin),
    .day_bin(day_bin), .month_bin(month_bin), .year_bin(year_bin),
    .sec_pulse(sec_pulse), .seg(seg)
`ifdef RTC_ALARM_EN
    , .alarm_set(alarm_set), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_clr(alarm_clr), .alarm(alarm)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_sec, m_min, m_hour, m_day, m_mon, m_year;
  int m_presc;
  bit m_check, m_ready, m_err, m_pulse;
  logic [97:0] m_seg;
  int l_sec, l_min, l_hour, l_day, l_mon, l_year;
  bit a_armed, a_alarm;
  int a_h, a_m;
  bit s_run, s_lv, s_aset, s_aclr;
  int s_sec, s_min, s_hour, s_day, s_mon, s_year, s_ah, s_am;

  function automatic bit m_leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int m_dim(int mo, int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo == 2 && m_leap(y)) return 29;
    return t[mo-1];
  endfunction

  function automatic bit m_load_ok(int s, int mi, int h, int d, int mo, int y);
    if (mo < 1 || mo > 12) return 1'b0;
    return (s <= 59) && (mi <= 59) && (h <= 23) && (d >= 1) && (d <= m_dim(mo, y)) && (y <= 9999);
  endfunction

  function automatic logic [6:0] seg_of(int v);
    logic [6:0] p;
    case (v)
      0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F; 4: p = 7'h66;
      5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07; 8: p = 7'h7F; 9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return SEG_AL ? ~p : p;
  endfunction

  function automatic logic [97:0] enc_exp(int s, int mi, int h, int d, int mo, int y);
    int dg[14];
    logic [97:0] r;
    dg = '{s % 10, s / 10, mi % 10, mi / 10, h % 10, h / 10, d % 10, d / 10,
           mo % 10, mo / 10, y % 10, (y / 10) % 10, (y / 100) % 10, y / 1000};
    r = '0;
    for (int i = 0; i < 14; i++) r[i*7 +: 7] = seg_of(dg[i]);
    return r;
  endfunction

  // One second later: bump, then normalise each field in turn.
  function automatic void add_second();
    m_sec++;
    if (m_sec == 60) begin m_sec = 0; m_min++; end
    if (m_min == 60) begin m_min = 0; m_hour++; end
    if (m_hour == 24) begin m_hour = 0; m_day++; end
    if (m_day > m_dim(m_mon, m_year)) begin m_day = 1; m_mon++; end
    if (m_mon == 13) begin m_mon = 1; m_year++; end
    if (m_year == 10000) m_year = 0;
  endfunction

  function automatic void model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = RESET_YEAR;
    m_presc = 0; m_check = 0; m_ready = 1; m_err = 0; m_pulse = 0;
    m_seg = enc_exp(0, 0, 0, 1, 1, RESET_YEAR);
    a_armed = 0; a_alarm = 0; a_h = 0; a_m = 0;
  endfunction

  function automatic void model_edge();
    bit fire;
    fire = 0;
    m_seg = enc_exp(m_sec, m_min, m_hour, m_day, m_mon, m_year);
    m_err = 0;
    m_pulse = 0;
    if (m_check) begin
      if (m_load_ok(l_sec, l_min, l_hour, l_day, l_mon, l_year)) begin
        m_sec = l_sec; m_min = l_min; m_hour = l_hour;
        m_day = l_day; m_mon = l_mon; m_year = l_year;
        m_presc = 0;
      end else begin
        m_err = 1;
      end
      m_check = 0;
      m_ready = 1;
    end else begin
      if (s_run) begin
        if (m_presc == CLK_DIV - 1) begin
          m_presc = 0;
          add_second();
          m_pulse = 1;
          fire = a_armed && (m_hour == a_h) && (m_min == a_m) && (m_sec == 0);
        end else begin
          m_presc++;
        end
      end
      if (s_lv && m_ready) begin
        l_sec = s_sec; l_min = s_min; l_hour = s_hour;
        l_day = s_day; l_mon = s_mon; l_year = s_year;
        m_check = 1;
        m_ready = 0;
      end
    end
    if (s_aset) begin a_armed = 1; a_h = s_ah; a_m = s_am; end
    if (s_aclr) a_alarm = 0;
    else if (fire) a_alarm = 1;
  endfunction

  task automatic compare_all();
    check_eq("time", 128'({sec_bin, min_bin, hour_bin, day_bin, month_bin, year_bin}),
             128'({6'(m_sec), 6'(m_min), 5'(m_hour), 5'(m_day), 4'(m_mon), 14'(m_year)}));
    check_eq("ctl", 128'({load_ready, load_err, sec_pulse}), 128'({m_ready, m_err, m_pulse}));
    check_eq("seg", 128'(seg), 128'(m_seg));
`ifdef RTC_ALARM_EN
    check_eq("alarm", 128'(alarm), 128'(a_alarm));
`endif
  endtask

  // Advance one clock: snapshot the inputs the DUT will sample, then predict and compare.
  task automatic cyc();
    s_run = run; s_lv = load_valid; s_aset = alarm_set; s_aclr = alarm_clr;
    s_sec = int'(load_sec); s_min = int'(load_min); s_hour = int'(load_hour);
    s_day = int'(load_day); s_mon = int'(load_month); s_year = int'(load_year);
    s_ah = int'(alarm_hour); s_am = int'(alarm_min);
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic do_load(input int s, input int mi, input int h, input int d, input int mo,
                         input int y, output bit rdy_after, output bit err_after);
    load_sec = 6'(s); load_min = 6'(mi); load_hour = 5'(h);
    load_day = 5'(d); load_month = 4'(mo); load_year = 14'(y);
    load_valid = 1'b1;
    cyc();
    rdy_after = load_ready;
    load_valid = 1'b0;
    cyc();
    err_after = load_err;
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * CLK_DIV + 2 && !seen; i++) begin
      cyc();
      seen = sec_pulse;
    end
    check_eq(tag, 128'(seen), 128'(1'b1));
  endtask

  initial begin
    bit rdy, err;
    int pulses;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    run = 1'b1;

    // Free run: first pulse on the 4th edge, seconds 0 -> 1.
    for (int i = 1; i <= CLK_DIV; i++) begin
      cyc();
      check_eq("first_pulse", 128'(sec_pulse), 128'(i == CLK_DIV));
    end
    check_eq("sec_after_tick", 128'(sec_bin), 128'(6'd1));
    cyc();
    check_eq("seg_sec0_lag", 128'(seg[6:0]), 128'(seg_of(1)));
    repeat (6) cyc();

    // Full wrap to year 0.
    do_load(59, 59, 23, 31, 12, 9999, rdy, err);
    check_eq("wrap_load_err", 128'(err), 128'(1'b0));
    wait_tick("wrap_tick");
    check_eq("wrap_year", 128'(year_bin), 128'(14'd0));
    check_eq("wrap_date", 128'({day_bin, month_bin, hour_bin}), 128'({5'd1, 4'd1, 5'd0}));

    // February end in century / 400-year / ordinary leap years.
    do_load(59, 59, 23, 28, 2, 2100, rdy, err);
    wait_tick("feb2100_tick");
    check_eq("feb2100", 128'({day_bin, month_bin}), 128'({5'd1, 4'd3}));
    do_load(59, 59, 23, 28, 2, 2000, rdy, err);
    wait_tick("feb2000_tick");
    check_eq("feb2000", 128'({day_bin, month_bin}), 128'({5'd29, 4'd2}));
    do_load(59, 59, 23, 28, 2, 2024, rdy, err);
    wait_tick("feb2024_tick");
    check_eq("feb2024", 128'({day_bin, month_bin}), 128'({5'd29, 4'd2}));

    // Rejected loads.
    do_load(10, 10, 10, 31, 4, 2024, rdy, err);
    check_eq("apr31_ready_low", 128'(rdy), 128'(1'b0));
    check_eq("apr31_err", 128'(err), 128'(1'b1));
    cyc();
    check_eq("err_one_cycle", 128'(load_err), 128'(1'b0));
    do_load(60, 0, 0, 1, 1, 2024, rdy, err);
    check_eq("sec60_err", 128'(err), 128'(1'b1));

    // Frozen time.
    run = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      pulses += int'(sec_pulse);
    end
    check_eq("frozen_no_pulse", 128'(pulses), 128'(0));
    run = 1'b1;
    repeat (8) cyc();

`ifdef RTC_ALARM_EN
    do_load(55, 29, 7, 15, 6, 2024, rdy, err);
    alarm_set = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
    cyc();
    alarm_set = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        cyc();
        seen = alarm;
      end
      check_eq("alarm_fired", 128'(seen), 128'(1'b1));
    end
    check_eq("alarm_time", 128'({hour_bin, min_bin, sec_bin}), 128'({5'd7, 6'd30, 6'd0}));
    repeat (6) cyc();
    check_eq("alarm_sticky", 128'(alarm), 128'(1'b1));
    alarm_clr = 1'b1;
    cyc();
    alarm_clr = 1'b0;
    check_eq("alarm_cleared", 128'(alarm), 128'(1'b0));
`endif

    // Randomized traffic near the rollover boundaries.
    for (int i = 0; i < 600; i++) begin
      run = ($urandom_range(0, 9) != 0);
      load_valid = ($urandom_range(0, 9) == 0);
      load_sec   = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(55, 59));
      load_min   = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(58, 59));
      load_hour  = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : 23);
      load_day   = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(27, 31));
      load_month = 4'(($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12));
      case ($urandom_range(0, 6))
        0: load_year = 14'd0;
        1: load_year = 14'd2000;
        2: load_year = 14'd2100;
        3: load_year = 14'd9999;
        4: load_year = 14'd2023;
        5: load_year = 14'd2024;
        default: load_year = 14'($urandom_range(0, 10005));
      endcase
      alarm_set  = ($urandom_range(0, 49) == 0);
      alarm_hour = 5'($urandom_range(0, 23));
      alarm_min  = 6'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 59));
      alarm_clr  = ($urandom_range(0, 29) == 0);
      cyc();
    end
    load_valid = 1'b0; alarm_set = 1'b0; alarm_clr = 1'b0; run = 1'b1;
    repeat (2) cyc();

    // Reset while in CHECK.
    load_sec = 6'd5; load_min = 6'd6; load_hour = 5'd7;
    load_day = 5'd8; load_month = 4'd9; load_year = 14'd1999;
    load_valid = 1'b1;
    cyc();
    load_valid = 1'b0;
    check_eq("in_check", 128'(load_ready), 128'(1'b0));
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    check_eq("rst_no_err", 128'(load_err), 128'(1'b0));
    rst_n = 1'b1;
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
